// File: rtl/gen_user_clock_multi.sv
// gen_user_clock_multi
// N-channel divided-clock generator running from a single fabric clock.
// Each channel produces a ~50% duty divided clock (low phase first), a
// one-cycle tick in the last cycle of each period, and a stretched
// active-high reset held for RST_CYC divided periods. Divide ratios are
// loaded at runtime through a one-cycle write strobe and only take effect
// at a period boundary, so a period is never shortened or stretched.
// Optional feature macro: GEN_CLK_SYNC_EN (SYNC_IN phase-aligns all channels).
module gen_user_clock_multi #(
    parameter int NCH         = 2,
    parameter int CW          = 8,
    parameter int DIV_DEFAULT = 50,
    parameter int RST_CYC     = 5,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK_IN,
    input  logic              RSTN_IN,
    input  logic              CFG_WE,
    input  logic [CHW-1:0]    CFG_CH,
    input  logic [CW-1:0]     CFG_DIV,
    input  logic              SYNC_IN,
    output logic [NCH-1:0]    CLK_OUT,
    output logic [NCH-1:0]    TICK_OUT,
    output logic [NCH-1:0]    RST_OUT
);

    // Ratios below 2 cannot form a high and a low phase; clamp them to 2.
    function automatic logic [CW-1:0] eff_div(input logic [CW-1:0] v);
        return (v < CW'(2)) ? CW'(2) : v;
    endfunction

    // First count value of the high phase; odd ratios get the longer low phase.
    function automatic logic [CW-1:0] hi_start(input logic [CW-1:0] d);
        return d - (d >> 1);
    endfunction

    logic [CW-1:0]  cnt_r    [NCH];
    logic [CW-1:0]  div_r    [NCH];
    logic [CW-1:0]  pend_r   [NCH];
    logic [7:0]     pcnt_r   [NCH];
    logic [NCH-1:0] valid_r;
    logic [NCH-1:0] clk_r;
    logic [NCH-1:0] tick_r;
    logic [NCH-1:0] rst_r;

    logic [CW-1:0]  cnt_nx_s  [NCH];
    logic [CW-1:0]  div_nx_s  [NCH];
    logic [CW-1:0]  pend_nx_s [NCH];
    logic [7:0]     pcnt_nx_s [NCH];
    logic [NCH-1:0] valid_nx_s;
    logic [NCH-1:0] clk_nx_s;
    logic [NCH-1:0] tick_nx_s;
    logic [NCH-1:0] rst_nx_s;
    logic           sync_s;

`ifdef GEN_CLK_SYNC_EN
    assign sync_s = SYNC_IN;
`else
    // Without the sync feature the pin is accepted but has no function.
    logic unused_sync_s;
    assign sync_s        = 1'b0;
    assign unused_sync_s = SYNC_IN;
`endif

    // Next-state for every channel: counter, ratio apply, outputs, reset stretch.
    always_comb begin
        logic           wr_v;
        logic [CW-1:0]  pdiv_v;
        logic           pval_v;
        logic [CW-1:0]  dcur_v;
        logic [CW-1:0]  dnew_v;
        logic           wrap_v;
        logic           apply_v;
        wr_v    = 1'b0;
        pdiv_v  = '0;
        pval_v  = 1'b0;
        dcur_v  = '0;
        dnew_v  = '0;
        wrap_v  = 1'b0;
        apply_v = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            // A write landing in the wrap cycle is folded in before the apply decision.
            wr_v    = CFG_WE && (int'(CFG_CH) < NCH) && (int'(CFG_CH) == i);
            pdiv_v  = wr_v ? CFG_DIV : pend_r[i];
            pval_v  = wr_v | valid_r[i];
            dcur_v  = eff_div(div_r[i]);
            wrap_v  = (cnt_r[i] == (dcur_v - CW'(1)));
            apply_v = pval_v && (wrap_v || sync_s);

            pend_nx_s[i]  = pdiv_v;
            if (apply_v) begin
                div_nx_s[i]   = pdiv_v;
                valid_nx_s[i] = 1'b0;
            end else begin
                div_nx_s[i]   = div_r[i];
                valid_nx_s[i] = pval_v;
            end

            if (wrap_v || sync_s) begin
                cnt_nx_s[i] = '0;
            end else begin
                cnt_nx_s[i] = cnt_r[i] + CW'(1);
            end

            // Outputs are registered from the next count so they line up with it.
            dnew_v       = eff_div(div_nx_s[i]);
            clk_nx_s[i]  = (cnt_nx_s[i] >= hi_start(dnew_v));
            tick_nx_s[i] = (cnt_nx_s[i] == (dnew_v - CW'(1)));

            // A ratio applied at a wrap restarts the reset stretch; sync leaves it alone.
            if (apply_v && !sync_s) begin
                rst_nx_s[i]  = 1'b1;
                pcnt_nx_s[i] = 8'd0;
            end else if (rst_r[i] && wrap_v) begin
                if (pcnt_r[i] == 8'(RST_CYC - 1)) begin
                    rst_nx_s[i]  = 1'b0;
                    pcnt_nx_s[i] = 8'd0;
                end else begin
                    rst_nx_s[i]  = 1'b1;
                    pcnt_nx_s[i] = pcnt_r[i] + 8'd1;
                end
            end else begin
                rst_nx_s[i]  = rst_r[i];
                pcnt_nx_s[i] = pcnt_r[i];
            end
        end
    end

    // Channel state registers with asynchronous reset to the startup values.
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]  <= '0;
                div_r[i]  <= CW'(DIV_DEFAULT);
                pend_r[i] <= CW'(DIV_DEFAULT);
                pcnt_r[i] <= 8'd0;
            end
            valid_r <= '0;
            clk_r   <= '0;
            tick_r  <= '0;
            rst_r   <= '1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]  <= cnt_nx_s[i];
                div_r[i]  <= div_nx_s[i];
                pend_r[i] <= pend_nx_s[i];
                pcnt_r[i] <= pcnt_nx_s[i];
            end
            valid_r <= valid_nx_s;
            clk_r   <= clk_nx_s;
            tick_r  <= tick_nx_s;
            rst_r   <= rst_nx_s;
        end
    end

    assign CLK_OUT  = clk_r;
    assign TICK_OUT = tick_r;
    assign RST_OUT  = rst_r;

endmodule

// File: tb/tb_gen_user_clock_multi.sv
// Testbench for gen_user_clock_multi: the stimulus process pushes hand-computed
// per-cycle expectations into a time-ordered queue; the monitor samples the
// outputs on every falling edge and pops/compares the entries due that cycle.
module tb_gen_user_clock_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           sync_in;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick_out;
    logic [NCH-1:0] rst_out;

    gen_user_clock_multi #(.NCH(NCH), .CW(CW), .DIV_DEFAULT(50), .RST_CYC(5)) dut (
        .CLK_IN   (clk),
        .RSTN_IN  (rstn),
        .CFG_WE   (cfg_we),
        .CFG_CH   (cfg_ch),
        .CFG_DIV  (cfg_div),
        .SYNC_IN  (sync_in),
        .CLK_OUT  (clk_out),
        .TICK_OUT (tick_out),
        .RST_OUT  (rst_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   ch;
        int   sig;
        logic val;
    } exp_t;

    exp_t q[$];
    int   smp      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;
    bit   mon_done = 1'b0;

    function automatic string sig_name(input int s);
        return (s == 0) ? "CLK_OUT" : (s == 1) ? "TICK_OUT" : "RST_OUT";
    endfunction

    // Insert keeping the queue ordered by sample index.
    task automatic ex(input int cyc, input int ch, input int sig, input logic val);
        exp_t e;
        int   idx;
        e.cyc = cyc; e.ch = ch; e.sig = sig; e.val = val;
        idx = q.size();
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].cyc > cyc) begin
                idx = j;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    // Monitor: compare every expectation due at this sample.
    always @(negedge clk) begin
        exp_t e;
        logic act;
        while (q.size() > 0 && q[0].cyc <= smp) begin
            e = q.pop_front();
            case (e.sig)
                0:       act = clk_out[e.ch];
                1:       act = tick_out[e.ch];
                default: act = rst_out[e.ch];
            endcase
            n_tests++;
            if (e.cyc < smp) begin
                n_fail++;
                $display("FAIL late_%s[%0d] cyc %0d: checked at %0d, required at %0d",
                         sig_name(e.sig), e.ch, e.cyc, smp, e.cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s[%0d] cyc %0d: got %b, expected %b",
                         sig_name(e.sig), e.ch, e.cyc, act, e.val);
            end
        end
        if (done && !mon_done) begin
            n_tests++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d pending, expected 0", q.size());
            end
            mon_done = 1'b1;
        end
        smp++;
    end

    // Advance to posedge+1 of cycle t (sample index t not yet taken).
    task automatic go(input int t);
        while (smp < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int div);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 8'(div);
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
    endtask

    task automatic ex_reset(input int cyc);
        for (int c = 0; c < NCH; c++) begin
            ex(cyc, c, 0, 1'b0);
            ex(cyc, c, 1, 1'b0);
            ex(cyc, c, 2, 1'b1);
        end
    endtask

    int k0;
    int b;

    initial begin
        rstn    = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = 2'd0;
        cfg_div = 8'd0;
        sync_in = 1'b0;
        @(posedge clk);
        #1;
        go(3);
        ex_reset(3);
        go(5);
        k0   = smp;
        rstn = 1'b1;

        // Default ratio 50 on all channels, reset stretch of 5 periods.
        ex(k0+24, 0, 0, 1'b0); ex(k0+25, 0, 0, 1'b1); ex(k0+49, 0, 0, 1'b1);
        ex(k0+50, 0, 0, 1'b0); ex(k0+75, 0, 0, 1'b1);
        ex(k0+48, 0, 1, 1'b0); ex(k0+49, 0, 1, 1'b1); ex(k0+50, 0, 1, 1'b0);
        ex(k0+99, 0, 1, 1'b1);
        ex(k0+249, 0, 2, 1'b1); ex(k0+250, 0, 2, 1'b0);
        ex(k0+249, 1, 2, 1'b1); ex(k0+250, 1, 2, 1'b0);
        ex(k0+25, 2, 0, 1'b1);

        // Ch1 -> 7 mid-period; applied at wrap 299, ch0 undisturbed.
        go(k0+270);
        ex(k0+299, 1, 0, 1'b1); ex(k0+300, 1, 0, 1'b0); ex(k0+303, 1, 0, 1'b0);
        ex(k0+304, 1, 0, 1'b1); ex(k0+306, 1, 0, 1'b1); ex(k0+307, 1, 0, 1'b0);
        ex(k0+305, 1, 1, 1'b0); ex(k0+306, 1, 1, 1'b1); ex(k0+313, 1, 1, 1'b1);
        ex(k0+299, 1, 2, 1'b0); ex(k0+300, 1, 2, 1'b1);
        ex(k0+334, 1, 2, 1'b1); ex(k0+335, 1, 2, 1'b0);
        ex(k0+299, 0, 1, 1'b1); ex(k0+300, 0, 2, 1'b0); ex(k0+325, 0, 0, 1'b1);
        wr(1, 7);

        // Ch0: 10 then 20 in one period -> 20 only; ch1 ratio 0 -> period 2.
        go(k0+310);
        ex(k0+349, 0, 1, 1'b1); ex(k0+359, 0, 1, 1'b0); ex(k0+369, 0, 1, 1'b1);
        ex(k0+350, 0, 0, 1'b0); ex(k0+359, 0, 0, 1'b0); ex(k0+360, 0, 0, 1'b1);
        ex(k0+370, 0, 0, 1'b0);
        ex(k0+350, 0, 2, 1'b1); ex(k0+449, 0, 2, 1'b1); ex(k0+450, 0, 2, 1'b0);
        ex(k0+342, 1, 0, 1'b0); ex(k0+343, 1, 0, 1'b1); ex(k0+344, 1, 0, 1'b0);
        ex(k0+343, 1, 1, 1'b1); ex(k0+344, 1, 1, 1'b0);
        ex(k0+341, 1, 2, 1'b0); ex(k0+342, 1, 2, 1'b1);
        ex(k0+351, 1, 2, 1'b1); ex(k0+352, 1, 2, 1'b0);
        wr(0, 10);
        go(k0+320);
        wr(0, 20);
        go(k0+340);
        wr(1, 0);

        // Out-of-range channel index: nothing changes anywhere.
        go(k0+380);
        ex(k0+399, 2, 1, 1'b1); ex(k0+449, 2, 1, 1'b1);
        ex(k0+400, 2, 0, 1'b0); ex(k0+425, 2, 0, 1'b1);
        ex(k0+409, 0, 1, 1'b1); ex(k0+429, 0, 1, 1'b1);
        ex(k0+400, 1, 0, 1'b0); ex(k0+401, 1, 0, 1'b1); ex(k0+401, 1, 1, 1'b1);
        ex(k0+400, 1, 2, 1'b0); ex(k0+400, 2, 2, 1'b0);
        // Write coincident with ch1 wrap at 461 -> ratio 5 from 462.
        ex(k0+461, 1, 0, 1'b1); ex(k0+462, 1, 0, 1'b0); ex(k0+464, 1, 0, 1'b0);
        ex(k0+465, 1, 0, 1'b1); ex(k0+466, 1, 0, 1'b1); ex(k0+467, 1, 0, 1'b0);
        ex(k0+461, 1, 1, 1'b1); ex(k0+465, 1, 1, 1'b0); ex(k0+466, 1, 1, 1'b1);
        ex(k0+461, 1, 2, 1'b0); ex(k0+462, 1, 2, 1'b1);
        ex(k0+484, 0, 0, 1'b1);
        wr(3, 9);
        go(k0+461);
        wr(1, 5);

        // Asynchronous reset in ch0 high phase, then restart.
        go(k0+485);
        ex_reset(k0+485);
        rstn = 1'b0;
        go(k0+490);
        b    = smp;
        rstn = 1'b1;

        ex(b+24, 0, 0, 1'b0); ex(b+25, 0, 0, 1'b1); ex(b+49, 0, 1, 1'b1);
        ex(b+25, 1, 0, 1'b1);
        ex(b+50, 1, 2, 1'b1); ex(b+64, 1, 0, 1'b0); ex(b+65, 1, 0, 1'b1);
        ex(b+92, 1, 0, 1'b0); ex(b+93, 1, 0, 1'b1); ex(b+104, 1, 1, 1'b1);
        ex(b+183, 1, 0, 1'b0);
        ex(b+222, 1, 2, 1'b0); ex(b+272, 0, 2, 1'b0);
`ifdef GEN_CLK_SYNC_EN
        ex(b+175, 0, 0, 1'b0); ex(b+199, 0, 1, 1'b0); ex(b+179, 1, 1, 1'b0);
        ex(b+220, 0, 1, 1'b1); ex(b+195, 1, 1, 1'b1); ex(b+220, 1, 1, 1'b1);
        ex(b+206, 1, 2, 1'b1); ex(b+251, 0, 2, 1'b1); ex(b+184, 1, 0, 1'b1);
`else
        ex(b+175, 0, 0, 1'b1); ex(b+199, 0, 1, 1'b1); ex(b+179, 1, 1, 1'b1);
        ex(b+220, 0, 1, 1'b0); ex(b+195, 1, 1, 1'b0); ex(b+220, 1, 1, 1'b0);
        ex(b+206, 1, 2, 1'b0); ex(b+251, 0, 2, 1'b0); ex(b+184, 1, 0, 1'b0);
`endif
        go(b+10);
        wr(1, 30);
        go(b+55);
        wr(1, 25);
        go(b+170);
        sync_in = 1'b1;
        @(posedge clk);
        #1;
        sync_in = 1'b0;

        go(b+280);
        done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) begin
            @(posedge clk);
        end
        if (!mon_done) begin
            $display("FAIL monitor_stalled: got no drain check, expected one");
            $fatal(1, "monitor did not complete");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
